// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing back end.
package vga_timing_pkg;

  // 640x480 @ 60 Hz defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  // Idle raster state: both syncs released, outside the visible area
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that delays the raw sync/active decode so it lines up
// with colour coming back from the object mux. DEPTH=0 is a plain wire.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  resetN,
  input  sync_t i_d,
  output sync_t o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk & resetN;
      assign o_q = i_d;
    end else begin : g_shift
      sync_t r_sr [DEPTH];

      // Shift every clk; flush to the idle raster state on reset
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= SYNC_IDLE;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: pixel counters, sync/blank decode, latency-matched
// output register that gates colour to black outside the active area.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         pixelEn,
  input  logic [7:0]   redIn,
  input  logic [7:0]   greenIn,
  input  logic [7:0]   blueIn,
  output logic [10:0]  pixelX,
  output logic [10:0]  pixelY,
  output logic         startOfFrame,
  output logic         vgaHS,
  output logic         vgaVS,
  output logic         vgaBlankN,
  output logic [7:0]   vgaR,
  output logic [7:0]   vgaG,
  output logic [7:0]   vgaB
);

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t H_SYNC_S = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_E = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t V_SYNC_S = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_E = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  coord_t r_pixel_x;
  coord_t r_pixel_y;
  sync_t  w_raw;
  sync_t  w_dly;

  // Raster counters, advanced only on pixel-rate enables
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pixel_x <= '0;
      r_pixel_y <= '0;
    end else if (pixelEn) begin
      if (r_pixel_x == H_LAST) begin
        r_pixel_x <= '0;
        r_pixel_y <= (r_pixel_y == V_LAST) ? '0 : r_pixel_y + 1'b1;
      end else begin
        r_pixel_x <= r_pixel_x + 1'b1;
      end
    end
  end

  // Undelayed sync/active decode from the current counters
  always_comb begin
    w_raw        = SYNC_IDLE;
    w_raw.active = (r_pixel_x < H_ACT_C) && (r_pixel_y < V_ACT_C);
    w_raw.hs     = !((r_pixel_x >= H_SYNC_S) && (r_pixel_x < H_SYNC_E));
    w_raw.vs     = !((r_pixel_y >= V_SYNC_S) && (r_pixel_y < V_SYNC_E));
  end

  sync_delay_line #(.DEPTH(PIPE_DLY)) u_sync_dly (
    .clk    (clk),
    .resetN (resetN),
    .i_d    (w_raw),
    .o_q    (w_dly)
  );

  // Output register: sync, blank and colour leave on the same edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vgaHS     <= 1'b1;
      vgaVS     <= 1'b1;
      vgaBlankN <= 1'b0;
      vgaR      <= '0;
      vgaG      <= '0;
      vgaB      <= '0;
    end else begin
      vgaHS     <= w_dly.hs;
      vgaVS     <= w_dly.vs;
      vgaBlankN <= w_dly.active;
      vgaR      <= w_dly.active ? redIn   : 8'h00;
      vgaG      <= w_dly.active ? greenIn : 8'h00;
      vgaB      <= w_dly.active ? blueIn  : 8'h00;
    end
  end

  assign pixelX       = r_pixel_x;
  assign pixelY       = r_pixel_y;
  // Same clk as the enabled edge that wraps the raster back to (0,0)
  assign startOfFrame = pixelEn && (r_pixel_x == H_LAST) && (r_pixel_y == V_LAST);

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a shrunken raster
// (80 x 27 totals) so several whole frames fit in a short run.
module tb_vga_timing_controller;
  import vga_timing_pkg::*;

  // H: 64 active, fp 4, sync 8 (x=68..75), bp 4 -> 80
  // V: 20 active, fp 2, sync 2 (y=22..23), bp 3 -> 27; frame 2160 clk
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;

  logic        clk = 1'b0;
  logic        resetN;
  logic        pixelEn;
  logic [7:0]  redIn = 8'h00;
  logic [7:0]  greenIn = 8'hFF;
  logic [7:0]  blueIn = 8'h3C;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, vgaHS, vgaVS, vgaBlankN;
  logic [7:0]  vgaR, vgaG, vgaB;

  logic [10:0] pixelX0, pixelY0;
  logic        sof0, hs0, vs0, bl0;
  logic [7:0]  r0, g0, b0;

  int checks = 0;
  int failures = 0;

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(1)
  ) u_dut (
    .clk(clk), .resetN(resetN), .pixelEn(pixelEn),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .vgaHS(vgaHS), .vgaVS(vgaVS), .vgaBlankN(vgaBlankN),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  vga_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(0)
  ) u_dut0 (
    .clk(clk), .resetN(resetN), .pixelEn(pixelEn),
    .redIn(8'h5A), .greenIn(8'h00), .blueIn(8'h00),
    .pixelX(pixelX0), .pixelY(pixelY0), .startOfFrame(sof0),
    .vgaHS(hs0), .vgaVS(vs0), .vgaBlankN(bl0),
    .vgaR(r0), .vgaG(g0), .vgaB(b0)
  );

  always #5 clk = ~clk;

  // Emulated object mux: one register of latency from pixelX to colour
  always @(posedge clk) redIn <= pixelX[7:0];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic m_act(coord_t x, coord_t y);
    return (x < HA) && (y < VA);
  endfunction
  function automatic logic m_hs(coord_t x);
    return !((x >= HA + HF) && (x < HA + HF + HS));
  endfunction
  function automatic logic m_vs(coord_t y);
    return !((y >= VA + VF) && (y < VA + VF + VS));
  endfunction

  // Per-sample tracker (negedge), reset while trk_en is low
  logic   trk_en = 1'b0;
  int     div = 1;
  int     k;
  coord_t x_d1, x_d2, y_d1, y_d2, ex, ey;
  logic   en_d1, hs_p, vs_p, bl_p, a2, a1;
  bit     hs_f, vs_f, bl_f;
  int     hs_run, vs_run, bl_run, t_x68, t_vs0, last_sof, first_sof;
  int     e_model, e_model0, e_cnt, e_hs_len, e_hs_off, e_bl_len, e_vs_len, e_vs_off, e_sof;
  int     n_hs, n_vs, n_bl, n_sof;

  always @(negedge clk) begin
    if (!trk_en) begin
      k = 0; hs_p = 1'b1; vs_p = 1'b1; bl_p = 1'b0;
      hs_f = 0; vs_f = 0; bl_f = 0; hs_run = 0; vs_run = 0; bl_run = 0;
      t_x68 = -1000; t_vs0 = -1000; last_sof = -1; first_sof = -1;
      e_model = 0; e_model0 = 0; e_cnt = 0; e_hs_len = 0; e_hs_off = 0;
      e_bl_len = 0; e_vs_len = 0; e_vs_off = 0; e_sof = 0;
      n_hs = 0; n_vs = 0; n_bl = 0; n_sof = 0;
    end else begin
      if (k >= 1) begin
        ex = x_d1; ey = y_d1;
        if (en_d1) begin
          ex = (x_d1 == 79) ? 11'd0 : x_d1 + 11'd1;
          if (x_d1 == 79) ey = (y_d1 == 26) ? 11'd0 : y_d1 + 11'd1;
        end
        if (pixelX !== ex || pixelY !== ey) e_cnt++;
        a1 = m_act(x_d1, y_d1);
        if (bl0 !== a1 || hs0 !== m_hs(x_d1) || vs0 !== m_vs(y_d1) ||
            r0 !== (a1 ? 8'h5A : 8'h00) || g0 !== 8'h00 || b0 !== 8'h00 ||
            pixelX0 !== pixelX || pixelY0 !== pixelY || sof0 !== startOfFrame)
          e_model0++;
      end
      if (k >= 2) begin
        a2 = m_act(x_d2, y_d2);
        if (vgaBlankN !== a2 || vgaHS !== m_hs(x_d2) || vgaVS !== m_vs(y_d2)) e_model++;
        if (vgaR !== (a2 ? x_d2[7:0] : 8'h00) || vgaG !== (a2 ? 8'hFF : 8'h00) ||
            vgaB !== (a2 ? 8'h3C : 8'h00))
          e_model++;
      end
      if (startOfFrame !== (pixelEn && pixelX == 79 && pixelY == 26)) e_model++;
      if (startOfFrame) begin
        n_sof++;
        if (first_sof < 0) first_sof = k;
        if (last_sof >= 0 && k - last_sof != 2160 * div) e_sof++;
        last_sof = k;
      end
      if (pixelX == 68 && (k == 0 || x_d1 != 68)) t_x68 = k;
      if (pixelX == 0 && pixelY == 22 && (k == 0 || !(x_d1 == 0 && y_d1 == 22))) t_vs0 = k;
      if (k >= 1) begin
        if (!vgaHS) begin
          if (hs_p) begin
            hs_f = 1; hs_run = 1;
            if (k - t_x68 != 2) e_hs_off++;
          end else hs_run++;
        end else if (!hs_p && hs_f) begin
          n_hs++;
          if (hs_run != HS * div) e_hs_len++;
        end
        if (!vgaVS) begin
          if (vs_p) begin
            vs_f = 1; vs_run = 1;
            if (k - t_vs0 != 2) e_vs_off++;
          end else vs_run++;
        end else if (!vs_p && vs_f) begin
          n_vs++;
          if (vs_run != VS * 80 * div) e_vs_len++;
        end
        if (vgaBlankN) begin
          if (!bl_p) begin bl_f = 1; bl_run = 1; end
          else bl_run++;
        end else if (bl_p && bl_f) begin
          n_bl++;
          if (bl_run != HA * div) e_bl_len++;
        end
      end
      hs_p = vgaHS; vs_p = vgaVS; bl_p = vgaBlankN;
      x_d2 = x_d1; y_d2 = y_d1; x_d1 = pixelX; y_d1 = pixelY;
      en_d1 = pixelEn;
      k++;
    end
  end

  task automatic check_stats(input string ph, input int exp_first, input int exp_nsof);
    check_eq({ph, "_counter_seq_errs"}, e_cnt, 0);
    check_eq({ph, "_out_model_errs"}, e_model, 0);
    check_eq({ph, "_dly0_model_errs"}, e_model0, 0);
    check_eq({ph, "_hs_len_errs"}, e_hs_len, 0);
    check_eq({ph, "_hs_offset_errs"}, e_hs_off, 0);
    check_eq({ph, "_blank_len_errs"}, e_bl_len, 0);
    check_eq({ph, "_vs_len_errs"}, e_vs_len, 0);
    check_eq({ph, "_vs_offset_errs"}, e_vs_off, 0);
    check_eq({ph, "_sof_period_errs"}, e_sof, 0);
    check_eq({ph, "_first_sof_sample"}, first_sof, exp_first);
    check_eq({ph, "_sof_count"}, n_sof, exp_nsof);
    check_eq({ph, "_hs_runs_ge50"}, int'(n_hs >= 50), 1);
    check_eq({ph, "_vs_runs_ge2"}, int'(n_vs >= 2), 1);
    check_eq({ph, "_blank_runs_ge40"}, int'(n_bl >= 40), 1);
  endtask

  task automatic wait_xy(input int x, input int y, input string tag);
    int n = 0;
    while (!(pixelX == x && pixelY == y) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, int'(pixelX == x && pixelY == y), 1);
  endtask

  int x0;

  initial begin
    resetN = 1'b0;
    pixelEn = 1'b1;

    // Reset held 10 clk
    repeat (10) @(negedge clk);
    check_eq("rst_pixelX", int'(pixelX), 0);
    check_eq("rst_pixelY", int'(pixelY), 0);
    check_eq("rst_sof", int'(startOfFrame), 0);
    check_eq("rst_hs", int'(vgaHS), 1);
    check_eq("rst_vs", int'(vgaVS), 1);
    check_eq("rst_blankN", int'(vgaBlankN), 0);
    check_eq("rst_rgb", int'({vgaR, vgaG, vgaB}), 0);
    check_eq("rst_dly0_blankN_hs", int'({bl0, hs0}), 1);

    // Release; counting starts from (0,0), flushed delay line keeps blank low two clk
    @(posedge clk); #2 resetN = 1'b1; trk_en = 1'b1;
    @(negedge clk);
    check_eq("rel_x0", int'(pixelX), 0);
    check_eq("rel_blank_s0", int'(vgaBlankN), 0);
    @(negedge clk);
    check_eq("rel_x1", int'(pixelX), 1);
    check_eq("rel_blank_s1", int'(vgaBlankN), 0);
    @(negedge clk);
    check_eq("rel_x2", int'(pixelX), 2);
    check_eq("rel_blank_s2", int'(vgaBlankN), 1);
    check_eq("rel_red_s2", int'(vgaR), 0);
    @(negedge clk);
    check_eq("rel_x3", int'(pixelX), 3);
    check_eq("rel_red_s3", int'(vgaR), 1);

    // Two full frames at pixelEn=1
    repeat (4416) @(negedge clk);
    check_stats("p2", 2159, 2);

    // pixelEn toggling 1,0,1,0 starting at the frame wrap
    wait_xy(79, 26, "p5_reach_frame_end");
    @(posedge clk); #2 pixelEn = 1'b0; trk_en = 1'b0;
    @(posedge clk); #2 pixelEn = 1'b1; trk_en = 1'b1; div = 2;
    @(negedge clk);
    x0 = int'(pixelX);
    repeat (10) begin
      @(posedge clk); #2 pixelEn = ~pixelEn;
    end
    @(negedge clk);
    check_eq("p5_x_advance_10clk", int'(pixelX) - x0, 5);
    repeat (8990) begin
      @(posedge clk); #2 pixelEn = ~pixelEn;
    end
    check_stats("p5", 4318, 2);
    @(posedge clk); #2 pixelEn = 1'b1; trk_en = 1'b0; div = 1;

    // Reset pulse in the middle of an hsync pulse
    @(negedge clk);
    wait_xy(72, 10, "p6_reach_72_10");
    check_eq("p6_hs_low_before_rst", int'(vgaHS), 0);
    #1 resetN = 1'b0;
    #1;
    check_eq("p6_rst_xy", int'({pixelX, pixelY}), 0);
    check_eq("p6_rst_hs_vs_blank", int'({vgaHS, vgaVS, vgaBlankN}), 6);
    check_eq("p6_rst_rgb", int'({vgaR, vgaG, vgaB}), 0);
    @(posedge clk); #2 resetN = 1'b1; trk_en = 1'b1;
    repeat (4420) @(negedge clk);
    check_stats("p6", 2159, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
